// File: rtl/aq_axis_arb.sv
// aq_axis_arb: packet-level round-robin arbiter for N AXI-Stream requesters
// sharing one AXI-Stream master port. A grant is held from the first beat
// until the owner's TLAST beat is accepted, so packets never interleave.
// Packet and beat counters are kept for test visibility.
module aq_axis_arb #(
    parameter int N     = 4,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N-1:0]     PORT_MASK,
    input  logic [N*32-1:0]  S_AXIS_TDATA,
    input  logic [N*4-1:0]   S_AXIS_TSTRB,
    input  logic [N-1:0]     S_AXIS_TKEEP,
    input  logic [N-1:0]     S_AXIS_TLAST,
    input  logic [N-1:0]     S_AXIS_TVALID,
    output logic [N-1:0]     S_AXIS_TREADY,
    output logic [31:0]      M_AXIS_TDATA,
    output logic [3:0]       M_AXIS_TSTRB,
    output logic             M_AXIS_TKEEP,
    output logic             M_AXIS_TLAST,
    output logic             M_AXIS_TVALID,
    input  logic             M_AXIS_TREADY,
    output logic [N-1:0]     GRANT,
    output logic             BUSY,
    output logic [CNT_W-1:0] PKT_COUNT,
    output logic [CNT_W-1:0] BEAT_COUNT
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_RST = IW'(N - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [N-1:0]     r_grant;
    logic [N-1:0]     w_grant_next;
    // Index of the most recent grant; while BUSY it is also the owner index.
    logic [IW-1:0]    r_last;
    logic [IW-1:0]    w_last_next;
    logic [CNT_W-1:0] r_pkt_count;
    logic [CNT_W-1:0] r_beat_count;

    logic [31:0]      w_port_data [N];
    logic [3:0]       w_port_strb [N];
    logic [N-1:0]     w_eligible;
    logic             w_sel_found;
    logic [IW-1:0]    w_sel_idx;
    logic             w_accept;
    logic             w_pkt_done;

    // Split the flat requester buses into per-port lanes.
    for (genvar gi = 0; gi < N; gi++) begin : g_port
        assign w_port_data[gi] = S_AXIS_TDATA[32*gi +: 32];
        assign w_port_strb[gi] = S_AXIS_TSTRB[4*gi +: 4];
    end

    assign w_eligible = S_AXIS_TVALID & PORT_MASK;

    // Round-robin pick: first eligible port scanning upward from r_last+1,
    // wrapping modulo N. Scanned from the far end so the nearest one wins.
    always_comb begin
        int cand;
        cand        = 0;
        w_sel_found = 1'b0;
        w_sel_idx   = r_last;
        for (int k = N; k >= 1; k--) begin
            cand = int'(r_last) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (w_eligible[cand[IW-1:0]]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = cand[IW-1:0];
            end
        end
    end

    // Next-state logic and the combinational mux from the owner to the master port.
    always_comb begin
        w_state_next  = r_state;
        w_grant_next  = r_grant;
        w_last_next   = r_last;
        w_accept      = 1'b0;
        w_pkt_done    = 1'b0;
        S_AXIS_TREADY = '0;
        M_AXIS_TDATA  = '0;
        M_AXIS_TSTRB  = '0;
        M_AXIS_TKEEP  = 1'b0;
        M_AXIS_TLAST  = 1'b0;
        M_AXIS_TVALID = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_found) begin
                    w_state_next = ST_BUSY;
                    w_grant_next = {{(N-1){1'b0}}, 1'b1} << w_sel_idx;
                    w_last_next  = w_sel_idx;
                end
            end
            ST_BUSY: begin
                M_AXIS_TDATA          = w_port_data[r_last];
                M_AXIS_TSTRB          = w_port_strb[r_last];
                M_AXIS_TKEEP          = S_AXIS_TKEEP[r_last];
                M_AXIS_TLAST          = S_AXIS_TLAST[r_last];
                M_AXIS_TVALID         = S_AXIS_TVALID[r_last];
                S_AXIS_TREADY[r_last] = M_AXIS_TREADY;
                w_accept              = S_AXIS_TVALID[r_last] & M_AXIS_TREADY;
                w_pkt_done            = w_accept & S_AXIS_TLAST[r_last];
                if (w_pkt_done) begin
                    w_state_next = ST_IDLE;
                    w_grant_next = '0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_grant_next = '0;
            end
        endcase
    end

    // State, grant and round-robin pointer registers; LAST resets to N-1 so port 0 leads.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= LAST_RST;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_last  <= w_last_next;
        end
    end

    // Wrapping packet and beat counters; a reset mid-packet discards partial progress.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pkt_count  <= '0;
            r_beat_count <= '0;
        end else begin
            if (w_accept) begin
                r_beat_count <= r_beat_count + CNT_W'(1);
            end
            if (w_pkt_done) begin
                r_pkt_count <= r_pkt_count + CNT_W'(1);
            end
        end
    end

    assign GRANT      = r_grant;
    assign BUSY       = (r_state == ST_BUSY);
    assign PKT_COUNT  = r_pkt_count;
    assign BEAT_COUNT = r_beat_count;

endmodule

// File: tb/tb_aq_axis_arb.sv
// tb_aq_axis_arb: randomized and directed checks of aq_axis_arb against a
// packet-level behavioural model (owner index, round-robin pointer, counters).
module tb_aq_axis_arb;

    localparam int N  = 4;
    localparam int CW = 4;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  s;
        logic        k;
        logic        l;
    } beat_t;

    typedef struct {
        int          port;
        logic [31:0] d;
        logic        l;
        int          cyc;
    } acc_t;

    logic            CLK = 1'b0;
    logic            RST;
    logic [N-1:0]    PORT_MASK;
    logic [N*32-1:0] S_AXIS_TDATA;
    logic [N*4-1:0]  S_AXIS_TSTRB;
    logic [N-1:0]    S_AXIS_TKEEP;
    logic [N-1:0]    S_AXIS_TLAST;
    logic [N-1:0]    S_AXIS_TVALID;
    logic [N-1:0]    S_AXIS_TREADY;
    logic [31:0]     M_AXIS_TDATA;
    logic [3:0]      M_AXIS_TSTRB;
    logic            M_AXIS_TKEEP;
    logic            M_AXIS_TLAST;
    logic            M_AXIS_TVALID;
    logic            M_AXIS_TREADY;
    logic [N-1:0]    GRANT;
    logic            BUSY;
    logic [CW-1:0]   PKT_COUNT;
    logic [CW-1:0]   BEAT_COUNT;

    aq_axis_arb #(.N(N), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .PORT_MASK(PORT_MASK),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB),
        .S_AXIS_TKEEP(S_AXIS_TKEEP), .S_AXIS_TLAST(S_AXIS_TLAST),
        .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB),
        .M_AXIS_TKEEP(M_AXIS_TKEEP), .M_AXIS_TLAST(M_AXIS_TLAST),
        .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
        .GRANT(GRANT), .BUSY(BUSY), .PKT_COUNT(PKT_COUNT), .BEAT_COUNT(BEAT_COUNT)
    );

    always #5 CLK = ~CLK;

    // Sources: each port holds a queue of pending beats; en gates its valid.
    beat_t src_q [N][$];
    bit    en [N];

    // Behavioural model: owner (-1 when idle), last granted index, counters.
    int  m_owner, m_last, m_pkt, m_beat, cyc;
    bit  model_valid;
    int  n_checks, n_fail;

    // Observations of the DUT for directed, packet-level checks.
    int          dut_grants[$];
    int          dut_grant_cyc[$];
    acc_t        dut_acc[$];
    logic [N-1:0] prev_grant;
    bit          last_stalled;
    logic [31:0] stall_data;

    function automatic bit any_pending();
        bit r;
        r = 0;
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) r = 1;
        return r;
    endfunction

    function automatic int onehot_idx(logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic push_beat(int p, logic [31:0] d, logic l);
        beat_t b;
        b.d = d;
        b.s = 4'($urandom);
        b.k = 1'($urandom);
        b.l = l;
        src_q[p].push_back(b);
    endtask

    task automatic push_pkt(int p, int len, logic [31:0] base);
        for (int j = 0; j < len; j++) push_beat(p, base + 32'(j), (j == len - 1));
    endtask

    task automatic drive();
        beat_t b;
        for (int i = 0; i < N; i++) begin
            b = '0;
            if (src_q[i].size() > 0) b = src_q[i][0];
            S_AXIS_TDATA[32*i +: 32] = b.d;
            S_AXIS_TSTRB[4*i +: 4]   = b.s;
            S_AXIS_TKEEP[i]          = b.k;
            S_AXIS_TLAST[i]          = b.l;
            S_AXIS_TVALID[i]         = (src_q[i].size() > 0) && en[i];
        end
    endtask

    // One clock cycle: drive sources, compare DUT to model, log, advance model.
    task automatic cycle();
        logic [N-1:0] eg, etr;
        logic [38:0]  em, am;
        int           o, sel, p;
        beat_t        b;
        drive();
        #1;
        o   = m_owner;
        eg  = '0;
        etr = '0;
        em  = '0;
        if (o >= 0) begin
            eg  = N'(1) << o;
            etr = M_AXIS_TREADY ? eg : '0;
            em  = {S_AXIS_TDATA[32*o +: 32], S_AXIS_TSTRB[4*o +: 4], S_AXIS_TKEEP[o],
                   S_AXIS_TLAST[o], S_AXIS_TVALID[o]};
        end
        am = {M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TKEEP, M_AXIS_TLAST, M_AXIS_TVALID};
        if (model_valid) begin
            n_checks++;
            if ({GRANT, BUSY} !== {eg, (o >= 0)}) begin
                n_fail++;
                $display("FAIL grant_busy cyc=%0d got=%b/%b exp=%b/%b", cyc, GRANT, BUSY, eg, (o >= 0));
            end
            n_checks++;
            if (am !== em) begin
                n_fail++;
                $display("FAIL m_axis cyc=%0d got=%h exp=%h", cyc, am, em);
            end
            n_checks++;
            if (S_AXIS_TREADY !== etr) begin
                n_fail++;
                $display("FAIL s_tready cyc=%0d got=%b exp=%b", cyc, S_AXIS_TREADY, etr);
            end
            n_checks++;
            if ({PKT_COUNT, BEAT_COUNT} !== {CW'(m_pkt), CW'(m_beat)}) begin
                n_fail++;
                $display("FAIL counters cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, PKT_COUNT, BEAT_COUNT, m_pkt, m_beat);
            end
            if (last_stalled) begin
                n_checks++;
                if (M_AXIS_TDATA !== stall_data) begin
                    n_fail++;
                    $display("FAIL stall_hold cyc=%0d got=%h exp=%h", cyc, M_AXIS_TDATA, stall_data);
                end
            end
        end
        // DUT observation logs
        if (GRANT != '0 && prev_grant == '0) begin
            dut_grants.push_back(onehot_idx(GRANT));
            dut_grant_cyc.push_back(cyc);
        end
        prev_grant = GRANT;
        if (M_AXIS_TVALID && M_AXIS_TREADY)
            dut_acc.push_back('{onehot_idx(GRANT), M_AXIS_TDATA, M_AXIS_TLAST, cyc});
        last_stalled = (M_AXIS_TVALID === 1'b1) && !M_AXIS_TREADY && !RST;
        stall_data   = M_AXIS_TDATA;
        // Model advance at the coming rising edge
        if (RST) begin
            m_owner     = -1;
            m_last      = N - 1;
            m_pkt       = 0;
            m_beat      = 0;
            model_valid = 1;
        end else if (m_owner < 0) begin
            sel = -1;
            for (int k = N; k >= 1; k--) begin
                p = (m_last + k) % N;
                if (S_AXIS_TVALID[p] && PORT_MASK[p]) sel = p;
            end
            if (sel >= 0) begin
                m_owner = sel;
                m_last  = sel;
            end
        end else if (S_AXIS_TVALID[m_owner] && M_AXIS_TREADY) begin
            b      = src_q[m_owner].pop_front();
            m_beat = (m_beat + 1) % (1 << CW);
            if (b.l) begin
                m_pkt   = (m_pkt + 1) % (1 << CW);
                m_owner = -1;
            end
        end
        cyc++;
        @(negedge CLK);
    endtask

    task automatic clear_logs();
        dut_grants.delete();
        dut_grant_cyc.delete();
        dut_acc.delete();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            en[i] = 1;
        end
        PORT_MASK     = '1;
        M_AXIS_TREADY = 1'b1;
        clear_logs();
    endtask

    task automatic run_until_empty(int maxc, string tag);
        int c;
        c = 0;
        while ((any_pending() || m_owner >= 0) && c < maxc) begin
            cycle();
            c++;
        end
        n_checks++;
        if (any_pending() || m_owner >= 0) begin
            n_fail++;
            $display("FAIL timeout_%s got=%0d cycles exp=<%0d", tag, c, maxc);
        end
    endtask

    task automatic test_reset();
        do_reset();
        cycle();
        n_checks++;
        if ({GRANT, BUSY, PKT_COUNT, BEAT_COUNT, S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TDATA} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got grant=%b busy=%b pkt=%0d beat=%0d exp all 0", GRANT, BUSY, PKT_COUNT, BEAT_COUNT);
        end
        $display("test_reset done: checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_single();
        int t0;
        do_reset();
        push_beat(2, 32'h11, 0);
        push_beat(2, 32'h22, 0);
        push_beat(2, 32'h33, 1);
        t0 = cyc;
        run_until_empty(20, "single");
        cycle();
        n_checks++;
        if (dut_grants.size() != 1 || dut_grants[0] != 2 || dut_grant_cyc[0] != t0 + 1) begin
            n_fail++;
            $display("FAIL single_grant got n=%0d exp grant port 2 at cycle %0d", dut_grants.size(), t0 + 1);
        end
        n_checks++;
        if (dut_acc.size() != 3) begin
            n_fail++;
            $display("FAIL single_beats got=%0d exp=3", dut_acc.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                n_checks++;
                if (dut_acc[j].d !== 32'(8'h11 * (j + 1)) || dut_acc[j].l !== (j == 2) || dut_acc[j].cyc != t0 + 1 + j) begin
                    n_fail++;
                    $display("FAIL single_beat%0d got d=%h l=%b c=%0d exp d=%h l=%b c=%0d", j, dut_acc[j].d, dut_acc[j].l, dut_acc[j].cyc, 8'h11 * (j + 1), (j == 2), t0 + 1 + j);
                end
            end
        end
        n_checks++;
        if (PKT_COUNT !== CW'(1) || BEAT_COUNT !== CW'(3)) begin
            n_fail++;
            $display("FAIL single_counts got=%0d/%0d exp=1/3", PKT_COUNT, BEAT_COUNT);
        end
        $display("test_single done: checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int p = 0; p < N; p++) push_pkt(p, 2, 32'(p * 256 + r * 16));
        run_until_empty(100, "rr");
        n_checks++;
        if (dut_grants.size() != 12 || dut_acc.size() != 24) begin
            n_fail++;
            $display("FAIL rr_count got grants=%0d beats=%0d exp 12/24", dut_grants.size(), dut_acc.size());
        end else begin
            for (int g = 0; g < 12; g++) begin
                n_checks++;
                if (dut_grants[g] != g % N || (g > 0 && dut_grant_cyc[g] - dut_grant_cyc[g-1] != 3)
                    || dut_acc[2*g].port != g % N || dut_acc[2*g+1].port != g % N) begin
                    n_fail++;
                    $display("FAIL rr_order g=%0d got port=%0d exp=%0d", g, dut_grants[g], g % N);
                end
            end
        end
        $display("test_round_robin done: checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_backpressure();
        int c;
        do_reset();
        push_pkt(1, 4, 32'hA0);
        c = 0;
        while ((any_pending() || m_owner >= 0) && c < 20) begin
            M_AXIS_TREADY = (c % 2 == 1);
            cycle();
            c++;
        end
        M_AXIS_TREADY = 1'b1;
        n_checks++;
        if (dut_acc.size() != 4) begin
            n_fail++;
            $display("FAIL bp_beats got=%0d exp=4", dut_acc.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                n_checks++;
                if (dut_acc[j].port != 1 || dut_acc[j].d !== 32'hA0 + 32'(j) || (j > 0 && dut_acc[j].cyc - dut_acc[j-1].cyc != 2)) begin
                    n_fail++;
                    $display("FAIL bp_beat%0d got p=%0d d=%h exp p=1 d=%h", j, dut_acc[j].port, dut_acc[j].d, 32'hA0 + 32'(j));
                end
            end
        end
        $display("test_backpressure done: checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_mask();
        int c;
        do_reset();
        PORT_MASK = 4'b1010;
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < N; p++) push_pkt(p, 2, 32'(p * 16 + r));
        c = 0;
        while ((src_q[1].size() > 0 || src_q[3].size() > 0 || m_owner >= 0) && c < 40) begin
            cycle();
            c++;
        end
        n_checks++;
        if (dut_grants.size() != 4 || dut_grants[0] != 1 || dut_grants[1] != 3 || dut_grants[2] != 1 || dut_grants[3] != 3) begin
            n_fail++;
            $display("FAIL mask_grants got n=%0d exp 1,3,1,3", dut_grants.size());
        end
        // Clearing a port's mask bit mid-packet must not truncate its packet.
        do_reset();
        PORT_MASK = 4'b0010;
        push_pkt(1, 4, 32'hB0);
        push_pkt(0, 2, 32'hC0);
        c = 0;
        while (dut_acc.size() < 1 && c < 10) begin
            cycle();
            c++;
        end
        PORT_MASK = 4'b0001;
        run_until_empty(40, "mask");
        n_checks++;
        if (dut_acc.size() != 6 || dut_acc[3].port != 1 || dut_acc[3].l !== 1'b1 || dut_acc[0].port != 1 || dut_acc[4].port != 0) begin
            n_fail++;
            $display("FAIL mask_midpkt got beats=%0d exp 4 from port1 then 2 from port0", dut_acc.size());
        end
        $display("test_mask done: checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_reset_mid_packet();
        int c;
        do_reset();
        push_pkt(2, 5, 32'hD0);
        c = 0;
        while (dut_acc.size() < 2 && c < 10) begin
            cycle();
            c++;
        end
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        n_checks++;
        if (GRANT !== '0 || PKT_COUNT !== '0 || BEAT_COUNT !== '0) begin
            n_fail++;
            $display("FAIL rst_mid got grant=%b pkt=%0d beat=%0d exp 0/0/0", GRANT, PKT_COUNT, BEAT_COUNT);
        end
        clear_logs();
        push_pkt(3, 2, 32'hE3);
        push_pkt(0, 2, 32'hE0);
        run_until_empty(20, "rstmid");
        n_checks++;
        if (dut_grants.size() != 2 || dut_grants[0] != 0 || dut_grants[1] != 3) begin
            n_fail++;
            $display("FAIL rst_mid_prio got n=%0d first=%0d exp 0 then 3", dut_grants.size(), (dut_grants.size() > 0) ? dut_grants[0] : -1);
        end
        $display("test_reset_mid_packet done: checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int k = 0; k < 17; k++) push_beat(k % N, 32'(k), 1'b1);
        run_until_empty(100, "wrap");
        n_checks++;
        if (PKT_COUNT !== CW'(1) || BEAT_COUNT !== CW'(1)) begin
            n_fail++;
            $display("FAIL wrap got=%0d/%0d exp=1/1", PKT_COUNT, BEAT_COUNT);
        end
        $display("test_counter_wrap done: checks=%0d fails=%0d", n_checks, n_fail);
    endtask

    task automatic test_random();
        int pkts;
        do_reset();
        pkts = 0;
        for (int c = 0; c < 2000; c++) begin
            if (c % 64 == 0) PORT_MASK = N'($urandom);
            M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                en[i] = ($urandom_range(0, 3) != 0);
                if (src_q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    push_pkt(i, $urandom_range(1, 5), $urandom);
                    pkts++;
                end
            end
            cycle();
        end
        PORT_MASK     = '1;
        M_AXIS_TREADY = 1'b1;
        for (int i = 0; i < N; i++) en[i] = 1;
        run_until_empty(200, "random");
        // Packet integrity: the owning port may only change after a TLAST beat.
        for (int j = 1; j < dut_acc.size(); j++) begin
            if (dut_acc[j].port != dut_acc[j-1].port) begin
                n_checks++;
                if (dut_acc[j-1].l !== 1'b1) begin
                    n_fail++;
                    $display("FAIL interleave at beat %0d got port %0d after non-last beat of port %0d", j, dut_acc[j].port, dut_acc[j-1].port);
                end
            end
        end
        $display("test_random done: packets=%0d checks=%0d fails=%0d", pkts, n_checks, n_fail);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        cyc           = 0;
        model_valid   = 0;
        m_owner       = -1;
        m_last        = N - 1;
        m_pkt         = 0;
        m_beat        = 0;
        prev_grant    = '0;
        last_stalled  = 0;
        stall_data    = '0;
        RST           = 1'b1;
        PORT_MASK     = '1;
        M_AXIS_TREADY = 1'b1;
        S_AXIS_TDATA  = '0;
        S_AXIS_TSTRB  = '0;
        S_AXIS_TKEEP  = '0;
        S_AXIS_TLAST  = '0;
        S_AXIS_TVALID = '0;
        for (int i = 0; i < N; i++) en[i] = 1;
        @(negedge CLK);
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_mask();
        test_reset_mid_packet();
        test_counter_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aq_axis_arb.md
# aq_axis_arb

Packet-level round-robin arbiter that shares a single AXI-Stream master port among N AXI-Stream requesters. It sits between several stream sources (stimulus generators or upstream reduce lanes) and the single stream input of the reduce datapath. It grants one requester at a time and holds the grant until that requester's TLAST beat is accepted, so packets are never interleaved. It also keeps packet and beat counters for test visibility.

## Interface
- N, default 4, number of requester ports (legal 2..8)
- CNT_W, default 16, width of the packet and beat counters
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  synchronous reset, active-high
- PORT_MASK  in  N  bit i=1 enables requester i; sampled only in IDLE
- S_AXIS_TDATA  in  N*32  requester data, port i at [32*i+31:32*i]
- S_AXIS_TSTRB  in  N*4  requester strobes, port i at [4*i+3:4*i]
- S_AXIS_TKEEP  in  N  requester keep
- S_AXIS_TLAST  in  N  requester last
- S_AXIS_TVALID  in  N  requester valid
- S_AXIS_TREADY  out  N  requester ready
- M_AXIS_TDATA  out  32  shared output data
- M_AXIS_TSTRB  out  4  shared output strobes
- M_AXIS_TKEEP  out  1  shared output keep
- M_AXIS_TLAST  out  1  shared output last
- M_AXIS_TVALID  out  1  shared output valid
- M_AXIS_TREADY  in  1  downstream ready
- GRANT  out  N  one-hot current owner; 0 when idle
- BUSY  out  1  1 while in state BUSY
- PKT_COUNT  out  CNT_W  completed packets since reset, wraps
- BEAT_COUNT  out  CNT_W  accepted beats since reset, wraps

## Operation
- States: IDLE, BUSY.
- IDLE:
  - Eligible set is S_AXIS_TVALID & PORT_MASK.
  - If the set is non-empty, select the first eligible port scanning upward from LAST+1 modulo N, where LAST is the most recently granted index.
  - Register GRANT to the one-hot of the selection, update LAST, and go to BUSY.
  - All S_AXIS_TREADY are 0.
  - M_AXIS_TVALID, TDATA, TSTRB, TKEEP and TLAST are 0.
- BUSY, with owner g:
  - M_AXIS_TDATA, TSTRB, TKEEP, TLAST and TVALID mirror port g combinationally.
  - S_AXIS_TREADY[g] = M_AXIS_TREADY. All other TREADY bits are 0.
  - A beat is accepted when M_AXIS_TVALID & M_AXIS_TREADY.
  - On an accepted beat with TLAST=1: go to IDLE, clear GRANT, increment PKT_COUNT.
  - Owner deasserting TVALID mid-packet: hold grant and wait. There is no timeout.
  - PORT_MASK changes in BUSY do not affect the current packet. They apply at the next IDLE decision.
- BEAT_COUNT increments on every accepted beat, including the TLAST beat.
- Both counters wrap from 2^CNT_W-1 to 0.
- TKEEP and TSTRB are passed through untouched. The arbiter does not interpret them.
- A single-beat packet (TLAST on the first beat) is legal. It occupies one BUSY cycle when TREADY is high.

## Timing
- Reset (RST=1 at a rising edge) forces the following:
  - state IDLE, GRANT=0, BUSY=0, LAST=N-1 (so port 0 has first priority);
  - PKT_COUNT=0, BEAT_COUNT=0;
  - all S_AXIS_TREADY=0 and all M_AXIS_* outputs 0 from the next cycle.
- Reset mid-packet aborts the packet immediately. There is no completion of the packet and no counter update.
- Grant latency: eligible TVALID in IDLE cycle t gives GRANT and BUSY valid in cycle t+1. The first beat can be accepted in cycle t+1.
- Turnaround: TLAST accepted in cycle k gives IDLE in cycle k+1 and the next grant visible in cycle k+2. There is exactly one dead cycle between packets.
- Output path data and valid are combinational from the granted port. There is no added register stage.
- TREADY has one combinational path from M_AXIS_TREADY.
- Simultaneous TLAST acceptance and a new request on another port: the new request is evaluated in the following IDLE cycle, using the updated LAST.

## Test plan
- **Single requester.** After reset, port 2 sends a 3-beat packet 0x11, 0x22, 0x33 with TREADY=1 throughout.
  - Expect GRANT=4'b0100 one cycle after TVALID.
  - Expect output beats in 3 consecutive cycles, TLAST on 0x33.
  - Expect PKT_COUNT=1 and BEAT_COUNT=3.
- **Round-robin fairness.** All 4 ports hold TVALID with 2-beat packets continuously.
  - Expect grant order 0,1,2,3,0,…
  - Expect one idle cycle between packets.
  - Expect no beat interleaving across ports.
- **Backpressure.** M_AXIS_TREADY toggles 1,0,1,0 during a 4-beat packet from port 1.
  - Expect beats delivered only on ready cycles.
  - Expect TDATA stable while stalled.
  - Expect S_AXIS_TREADY[1] to equal M_AXIS_TREADY, and other TREADY bits to stay 0.
- **Mask.**
  - With PORT_MASK=4'b1010 and ports 0–3 all valid, expect grants only to 1 and 3, alternating.
  - Clearing bit 1 mid-packet from port 1 does not truncate that packet.
- **Reset mid-packet.** Assert RST after beat 2 of a 5-beat packet.
  - Expect GRANT=0, PKT_COUNT=0 and BEAT_COUNT=0 on the next cycle.
  - After release, with ports 0 and 3 valid, expect port 0 granted first.
- **Counter wrap.** Set CNT_W=4 and run 17 single-beat packets.
  - Expect PKT_COUNT=1 and BEAT_COUNT=1.
